// File: rtl/pds_target.sv
// pds_target: 68000-style slave with four 16-bit registers and programmable wait states.
// Optional feature: define PDS_TARGET_BERR_EN so that an access with A[3]=1 answers with
// nBERR instead of being ignored.
// Ports:
//   C16M          clock, all state on posedge
//   RES           synchronous active-high reset
//   nAS/nUDS/nLDS async bus strobes (active-low), RnW bus direction (1 = read)
//   SEL           address decode hit, A[3:1] register address, Din write data
//   Dout          registered read data, nDoutOE read buffer enable (active-low)
//   nDTACK/nBERR  registered acknowledge / bus error (active-low)
//   CTRL          copy of register 0, BUSY high while a cycle is in progress
module pds_target #(
  parameter int unsigned WS = 2
) (
  input  logic        C16M,
  input  logic        RES,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        RnW,
  input  logic        SEL,
  input  logic [3:1]  A,
  input  logic [15:0] Din,
  output logic [15:0] Dout,
  output logic        nDoutOE,
  output logic        nDTACK,
  output logic        nBERR,
  output logic [15:0] CTRL,
  output logic        BUSY
);

`ifdef PDS_TARGET_BERR_EN
  localparam bit BerrEn = 1'b1;
`else
  localparam bit BerrEn = 1'b0;
`endif

  localparam int unsigned CntW = 4;
  localparam int unsigned DatW = 16;

  typedef enum logic [1:0] {IDLE, DECODE, WAIT, ACK} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          sync1_q, sync2_q;  // {nAS, nUDS, nLDS, RnW}
  logic [1:0]          idx_q, idx_d;
  logic                rnw_q, rnw_d;
  logic                uen_q, uen_d;
  logic                len_q, len_d;
  logic                berr_q, berr_d;
  logic [DatW-1:0]     regs_q [4];
  logic [DatW-1:0]     dout_q;
  logic                noe_q, ndtack_q, nberr_q, busy_q;
  logic                wr_en;
  logic                as_s, uds_s, lds_s, rnw_s;

  assign as_s  = sync2_q[3];
  assign uds_s = sync2_q[2];
  assign lds_s = sync2_q[1];
  assign rnw_s = sync2_q[0];

  // Next-state logic; an AS negation before ACK aborts the cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rnw_d   = rnw_q;
    uen_d   = uen_q;
    len_d   = len_q;
    berr_d  = berr_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!as_s && SEL) state_d = DECODE;
      end
      DECODE: begin
        if (as_s) begin
          state_d = IDLE;
        end else if (!uds_s || !lds_s) begin
          if (A[3] && !BerrEn) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
            idx_d   = A[2:1];
            rnw_d   = rnw_s;
            uen_d   = !uds_s;
            len_d   = !lds_s;
            berr_d  = A[3];
            cnt_d   = CntW'(WS);
          end
        end
      end
      WAIT: begin
        if (as_s) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = ACK;
          wr_en   = !rnw_q && !berr_q;
        end
      end
      ACK: begin
        if (as_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, synchronizer and output registers.
  always_ff @(posedge C16M) begin
    if (RES) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sync1_q  <= 4'b1111;
      sync2_q  <= 4'b1111;
      idx_q    <= '0;
      rnw_q    <= 1'b1;
      uen_q    <= 1'b0;
      len_q    <= 1'b0;
      berr_q   <= 1'b0;
      dout_q   <= '0;
      noe_q    <= 1'b1;
      ndtack_q <= 1'b1;
      nberr_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync1_q  <= {nAS, nUDS, nLDS, RnW};
      sync2_q  <= sync1_q;
      idx_q    <= idx_d;
      rnw_q    <= rnw_d;
      uen_q    <= uen_d;
      len_q    <= len_d;
      berr_q   <= berr_d;
      if (state_q == DECODE && state_d == WAIT && rnw_d && !berr_d) dout_q <= regs_q[idx_d];
      noe_q    <= !((state_d == WAIT || state_d == ACK) && rnw_d && !berr_d);
      ndtack_q <= !(state_d == ACK && !berr_d);
      nberr_q  <= !(BerrEn && state_d == ACK && berr_d);
      busy_q   <= (state_d != IDLE);
    end
  end

  // Register file: byte-lane write on the edge entering ACK.
  always_ff @(posedge C16M) begin
    if (RES) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      if (uen_q) regs_q[idx_q][15:8] <= Din[15:8];
      if (len_q) regs_q[idx_q][7:0]  <= Din[7:0];
    end
  end

  assign Dout    = dout_q;
  assign nDoutOE = noe_q;
  assign nDTACK  = ndtack_q;
  assign nBERR   = nberr_q;
  assign CTRL    = regs_q[0];
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_pds_target.sv
// tb_pds_target: directed bus cycles against a transaction-level model of pds_target.
module tb_pds_target;
  localparam int unsigned WS = 2;
`ifdef PDS_TARGET_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  logic        C16M = 1'b0;
  logic        RES  = 1'b1;
  logic        nAS  = 1'b1;
  logic        nUDS = 1'b1;
  logic        nLDS = 1'b1;
  logic        RnW  = 1'b1;
  logic        SEL  = 1'b0;
  logic [3:1]  A    = 3'b000;
  logic [15:0] Din  = 16'h0000;
  logic [15:0] Dout;
  logic        nDoutOE, nDTACK, nBERR, BUSY;
  logic [15:0] CTRL;

  pds_target #(.WS(WS)) dut (
    .C16M(C16M), .RES(RES), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .RnW(RnW),
    .SEL(SEL), .A(A), .Din(Din), .Dout(Dout), .nDoutOE(nDoutOE),
    .nDTACK(nDTACK), .nBERR(nBERR), .CTRL(CTRL), .BUSY(BUSY)
  );

  always #5 C16M = ~C16M;

  // Model state: register contents and the output levels expected after each edge.
  logic [15:0] mem [4];
  logic [15:0] exp_dout  = 16'h0000;
  logic        exp_noe   = 1'b1;
  logic        exp_dtack = 1'b1;
  logic        exp_berr  = 1'b1;
  logic        exp_busy  = 1'b0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs change on posedge; compare on every negedge.
  always @(negedge C16M) begin
    chk("nDTACK",  16'(nDTACK),  16'(exp_dtack));
    chk("nBERR",   16'(nBERR),   16'(exp_berr));
    chk("nDoutOE", 16'(nDoutOE), 16'(exp_noe));
    chk("BUSY",    16'(BUSY),    16'(exp_busy));
    chk("Dout",    Dout,         exp_dout);
    chk("CTRL",    CTRL,         mem[0]);
  end

  // One bus cycle. Strobes assert together; edge 1 is the first edge sampling them.
  // Strobes are released right after edge rel_e; RES is pulsed at edge rst_e (0 = never).
  task automatic bus_cycle(input logic [3:1] a, input logic rnw, input logic u, input logic l,
                           input logic [15:0] d, input int rel_e, input int rst_e,
                           output int resp_e);
    int  end_e, ack_e;
    bit  valid, bm, acked, unmapped, killed;
    logic [1:0] idx;
    end_e    = rel_e + 3;          // two sync flops plus the state transition
    ack_e    = WS + 5;
    valid    = (a[3] == 1'b0);
    bm       = a[3] && BERR_EN;
    unmapped = a[3] && !BERR_EN;
    acked    = (valid || bm) && (end_e > ack_e);
    idx      = a[2:1];
    killed   = 1'b0;
    resp_e   = 0;
    nAS = 1'b0; nUDS = !u; nLDS = !l; RnW = rnw; A = a; Din = d; SEL = 1'b1;
    for (int e = 1; e <= end_e + 2; e++) begin
      @(posedge C16M); #1;
      if (e == 3) SEL = 1'b0;
      if (e == rel_e) begin nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; RnW = 1'b1; end
      if (rst_e != 0 && e == rst_e - 1) RES = 1'b1;
      if (resp_e == 0 && (nDTACK === 1'b0 || nBERR === 1'b0)) resp_e = e;
      if (e == ack_e && acked && valid && !rnw && !killed) begin
        if (u) mem[idx][15:8] = d[15:8];
        if (l) mem[idx][7:0]  = d[7:0];
      end
      if (e == 4 && valid && rnw) exp_dout = mem[idx];
      if (rst_e != 0 && e == rst_e) begin
        RES = 1'b0;
        killed = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
        exp_dout = 16'h0000;
      end
      exp_busy  = !killed && (unmapped ? (e == 3) : (e >= 3 && e < end_e));
      exp_dtack = !(!killed && valid && acked && e >= ack_e && e < end_e);
      exp_berr  = !(!killed && bm && acked && e >= ack_e && e < end_e);
      exp_noe   = !(!killed && valid && rnw && e >= 4 && e < end_e);
    end
  endtask

  initial begin
    int re;
    for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
    repeat (2) @(posedge C16M);
    #1 RES = 1'b0;
    @(posedge C16M); #1;
    chk("reset_ctrl", CTRL, 16'h0000);
    chk("reset_dout", Dout, 16'h0000);

    // Word write to register 1; acknowledge lands on edge WS+5.
    bus_cycle(3'b001, 1'b0, 1'b1, 1'b1, 16'hA55A, 9, 0, re);
    chk("wr_ack_edge", 16'(re), 16'd7);

    // Lane writes into register 0.
    bus_cycle(3'b000, 1'b0, 1'b0, 1'b1, 16'h1234, 9, 0, re);
    chk("ctrl_low_lane", CTRL, 16'h0034);
    bus_cycle(3'b000, 1'b0, 1'b1, 1'b0, 16'hAB00, 9, 0, re);
    chk("ctrl_high_lane", CTRL, 16'hAB34);

    // Read back register 1.
    bus_cycle(3'b001, 1'b1, 1'b1, 1'b1, 16'h0000, 9, 0, re);
    chk("rd_ack_edge", 16'(re), 16'd7);
    chk("rd_reg1", Dout, 16'hA55A);

    // Write to register 2 aborted during WAIT, then read it back.
    bus_cycle(3'b010, 1'b0, 1'b1, 1'b1, 16'hFFFF, 3, 0, re);
    chk("abort_no_ack", 16'(re), 16'd0);
    bus_cycle(3'b010, 1'b1, 1'b1, 1'b1, 16'h0000, 9, 0, re);
    chk("rd_reg2_after_abort", Dout, 16'h0000);

    // Write to register 3 with acknowledge released one edge after ACK, read back.
    bus_cycle(3'b011, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5, 0, re);
    bus_cycle(3'b011, 1'b1, 1'b0, 1'b1, 16'h0000, 6, 0, re);
    chk("rd_reg3", Dout, 16'h0F0F);

    // Unmapped A[3]=1 access; must not disturb register 1.
    bus_cycle(3'b101, 1'b0, 1'b1, 1'b1, 16'h5555, 9, 0, re);
    chk("a3_resp_edge", 16'(re), BERR_EN ? 16'd7 : 16'd0);
    bus_cycle(3'b001, 1'b1, 1'b1, 1'b1, 16'h0000, 9, 0, re);
    chk("rd_reg1_after_a3", Dout, 16'hA55A);

    // Reset while in ACK of a write to register 3.
    bus_cycle(3'b011, 1'b0, 1'b1, 1'b1, 16'hBEEF, 9, 8, re);
    chk("rst_ctrl", CTRL, 16'h0000);
    chk("rst_dtack", 16'(nDTACK), 16'd1);
    bus_cycle(3'b001, 1'b1, 1'b1, 1'b1, 16'h0000, 9, 0, re);
    chk("rd_reg1_after_rst", Dout, 16'h0000);

    @(posedge C16M); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pds_target.md
PDS_TARGET -- requirements
Module: pds_target

Interface
REQ-001 SHALL have parameter WS, default 2, meaning C16M wait-state cycles inserted before acknowledge (0..15).
REQ-002 SHALL have port C16M  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port RES  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port nAS  input  1  68000 address strobe, asynchronous.
REQ-005 SHALL have port nUDS  input  1  upper data strobe, asynchronous.
REQ-006 SHALL have port nLDS  input  1  lower data strobe, asynchronous.
REQ-007 SHALL have port RnW  input  1  bus direction, 1 = read.
REQ-008 SHALL have port SEL  input  1  external address decode hit, active-high.
REQ-009 SHALL have port A  input  3  address bits A[3:1].
REQ-010 SHALL have port Din  input  16  write data from bus latch.
REQ-011 SHALL have port Dout  output  16  registered read data to bus.
REQ-012 SHALL have port nDoutOE  output  1  read-data buffer enable, active-low.
REQ-013 SHALL have port nDTACK  output  1  data acknowledge, active-low, registered.
REQ-014 SHALL have port nBERR  output  1  bus error, active-low, registered.
REQ-015 SHALL have port CTRL  output  16  continuous copy of register 0.
REQ-016 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL pass nAS, nUDS, nLDS, RnW through two posedge C16M flops each; only the second-flop values drive the state machine.
REQ-018 SHALL implement states IDLE, DECODE, WAIT, ACK with a 4-bit wait counter.
REQ-019 IDLE -> DECODE when synced AS low and SEL high; otherwise remain IDLE.
REQ-020 DECODE -> WAIT when synced UDS or LDS low: latch A, RnW, lane enables; load counter = WS.
REQ-021 WAIT: counter nonzero -> decrement; counter zero -> ACK.
REQ-022 ACK -> IDLE on the edge where synced AS is high; remain otherwise.
REQ-023 Synced AS high in DECODE or WAIT -> IDLE; no write, no acknowledge (aborted cycle).
REQ-024 nDTACK SHALL go low on the edge entering ACK and high on the edge leaving ACK.
REQ-025 Register file: four 16-bit registers indexed by latched A[2:1]; A[3] must be 0 for a valid hit.
REQ-026 Write: on the edge entering ACK, update only lanes whose strobe was latched low (UDS -> [15:8], LDS -> [7:0]).
REQ-027 Read: Dout loaded from indexed register on edge entering WAIT; nDoutOE low from that edge until the edge leaving ACK.
REQ-028 Latency with both strobes falling with nAS: nDTACK low at posedge number WS+5, counting the first edge sampling them low.
REQ-029 Write issued while a read of same register is pending is impossible (single cycle in flight); back-to-back cycles require return to IDLE.

Reset
REQ-030 RES high at a posedge SHALL force IDLE, counter 0, all registers 0, Dout 0, nDTACK 1, nBERR 1, nDoutOE 1, BUSY 0, sync flops to negated levels.
REQ-031 RES mid-cycle SHALL abandon the cycle with no register write and release all outputs on that edge.

Configuration
REQ-032 Macro PDS_TARGET_BERR_EN defined: latched A[3]=1 follows identical timing but drives nBERR low instead of nDTACK, no write, nDoutOE stays high.
REQ-033 Macro undefined: A[3]=1 returns to IDLE from DECODE without any response; nBERR held constant 1.

Verification
REQ-034 WS=2, write 0xA55A to A=001 both strobes -> nDTACK low at edge 7, register 1 = 0xA55A, nDTACK high 1 edge after synced nAS high.
REQ-035 Write 0x1234 to reg 0 with only nLDS -> CTRL = 0x0034 (from reset 0); then nUDS-only 0xAB00 -> CTRL = 0xAB34.
REQ-036 Read reg 1 after REQ-034 -> Dout = 0xA55A, nDoutOE low from WAIT entry through ACK exit.
REQ-037 nAS negated during WAIT of write 0xFFFF to reg 2 -> no nDTACK pulse, register 2 stays 0, BUSY low next edge.
REQ-038 A=101 access: with PDS_TARGET_BERR_EN -> nBERR low at edge 7; without -> no response, BUSY low after DECODE.
REQ-039 RES asserted while in ACK -> nDTACK high, state IDLE, all registers 0 on that edge.
